// File: rtl/ram_pkg.sv
// Shared definitions for the RAM built-in self-test controller:
// default geometry, the data seed and the controller state encoding.
package ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 9;

    // XOR seed applied to the address to form the test data
    localparam logic [DEF_DATA_W-1:0] DEF_PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FINISH
    } bist_state_e;

endpackage

// File: rtl/ram_bist_pattern_gen.sv
// Combinational test-data generator: data = addr ^ PATTERN, bitwise
// inverted for the inverted sweep. The address is truncated or
// zero-extended to the data width before the XOR.
module ram_bist_pattern_gen
    import ram_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              invert,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] base;

    assign base = DATA_W'(addr) ^ PATTERN;
    assign data = invert ? ~base : base;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Built-in self-test initiator for a single-port synchronous RAM.
// Writes an address-derived pattern to every word, reads it back with a
// one-cycle compare latency, and reports pass/fail, a saturating error
// count and the first failing location.
// Optional feature macro: RAM_BIST_INV_PASS_EN adds a second sweep that
// uses the inverted pattern; errors accumulate across both sweeps.
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              inv_q, inv_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              exp_valid_q, exp_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    logic [DATA_W-1:0] wr_pat;
    logic [DATA_W-1:0] cmp_pat;
    logic              mismatch;

    // Write data is generated for the address the port will present next cycle
    ram_bist_pattern_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PATTERN(PATTERN)
    ) u_wr_pat (
        .addr  (cnt_d),
        .invert(inv_d),
        .data  (wr_pat)
    );

    // Expected read data follows the address issued one cycle earlier
    ram_bist_pattern_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PATTERN(PATTERN)
    ) u_cmp_pat (
        .addr  (exp_addr_q),
        .invert(inv_q),
        .data  (cmp_pat)
    );

    assign mismatch = exp_valid_q && (mem_dout != cmp_pat);

    // Sequencer: state, address counter, sweep polarity and port control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = READ;
                end
            end
            READ: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
`ifdef RAM_BIST_INV_PASS_EN
                if (!inv_q) begin
                    state_d = WRITE;
                    inv_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = FINISH;
                end
`else
                state_d = FINISH;
`endif
            end
            FINISH: begin
                state_d = IDLE;
                inv_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
        done_d      = (state_d == FINISH);
        mem_wr_en_d = (state_d == WRITE);
    end

    // Read-back compare and result capture
    always_comb begin
        exp_addr_d  = cnt_q;
        exp_valid_d = (state_q == READ);
        mem_din_d   = mem_wr_en_d ? wr_pat : '0;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        pass_d      = pass_q;

        if ((state_q == IDLE) && (state_d == WRITE)) begin
            err_cnt_d   = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
            pass_d      = 1'b0;
        end else if (mismatch) begin
            if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
                fail_addr_d = exp_addr_q;
                fail_data_d = mem_dout;
            end
        end

        if (state_d == FINISH) begin
            pass_d = (err_cnt_d == '0);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            exp_addr_q  <= '0;
            exp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            exp_addr_q  <= exp_addr_d;
            exp_valid_q <= exp_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = cnt_q;
    assign mem_din   = mem_din_q;

endmodule
